// File: rtl/ho_host_seq.sv
// Host-side command sequencer for the obfuscated AES core: accepts one command at a time,
// issues the matching one-cycle strobe with registered operands, and returns one response.
module ho_host_seq #(
  parameter  int unsigned TIMEOUT = 1023,
  parameter  int unsigned TO_W    = 10,
  localparam int unsigned DATA_W  = 128,
  localparam int unsigned SEED_W  = 80,
  localparam int unsigned KEY_W   = 64
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [SEED_W-1:0] cmd_seed,
  input  logic [SEED_W-1:0] cmd_iv,
  input  logic [KEY_W-1:0]  cmd_key,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] Kin,
  output logic              Krdy,
  input  logic              Kvld,
  output logic [DATA_W-1:0] Din,
  output logic              Drdy,
  input  logic              Dvld,
  input  logic [DATA_W-1:0] Dout,
  input  logic              BSY,
  output logic              EN,
  output logic              reseed,
  output logic [SEED_W-1:0] newseed,
  output logic [SEED_W-1:0] newIV,
  output logic [KEY_W-1:0]  Key,
  output logic [SEED_W-1:0] Ukey_seed,
  output logic [SEED_W-1:0] User_IV,
  output logic              Key_ready_user,
  input  logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OP_LOAD_KEY = 2'd0, OP_ENCRYPT = 2'd1,
                            OP_UNLOCK = 2'd2, OP_RESEED = 2'd3} op_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_NOKEY   = 2'd2;

  state_t            state, state_d;
  op_t               op_q, op_d;
  logic [TO_W-1:0]   cnt, cnt_d;
  logic              key_loaded, key_loaded_d;
  logic              krdy_d, drdy_d, kru_d, reseed_d;
  logic              rsp_valid_d;
  logic [1:0]        rsp_status_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              cmd_ready_d;
  logic              accept_c, ack_c, limit_c;

  assign accept_c = cmd_valid & cmd_ready;
  assign limit_c  = (cnt == TO_W'(TIMEOUT - 1));
  // RESEED has no acknowledge channel and completes on its first WAIT cycle
  assign ack_c    = (op_q == OP_LOAD_KEY) ? Kvld :
                    (op_q == OP_ENCRYPT)  ? Dvld :
                    (op_q == OP_UNLOCK)   ? done : 1'b1;

  // Next-state, strobe and response logic
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    cnt_d        = cnt;
    key_loaded_d = key_loaded;
    krdy_d       = 1'b0;
    drdy_d       = 1'b0;
    kru_d        = 1'b0;
    reseed_d     = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status;
    rsp_data_d   = rsp_data;
    cmd_ready_d  = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          op_d    = op_t'(cmd_op);
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt + TO_W'(1);
        if (op_q == OP_ENCRYPT && !key_loaded) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_NOKEY;
          rsp_data_d   = '0;
          state_d      = IDLE;
        end else if (limit_c) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = '0;
          if (op_q == OP_LOAD_KEY) key_loaded_d = 1'b0;
          state_d      = IDLE;
        end else if (!(op_q == OP_ENCRYPT && BSY)) begin
          case (op_q)
            OP_LOAD_KEY: krdy_d   = 1'b1;
            OP_ENCRYPT:  drdy_d   = 1'b1;
            OP_UNLOCK:   kru_d    = 1'b1;
            OP_RESEED:   reseed_d = 1'b1;
          endcase
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt + TO_W'(1);
        // an acknowledge on the timeout edge still counts as success
        if (ack_c) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_data_d   = (op_q == OP_ENCRYPT) ? Dout : '0;
          if (op_q == OP_LOAD_KEY) key_loaded_d = 1'b1;
          state_d      = IDLE;
        end else if (limit_c) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = '0;
          if (op_q == OP_LOAD_KEY) key_loaded_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State, control and response registers
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state          <= IDLE;
      op_q           <= OP_LOAD_KEY;
      cnt            <= '0;
      key_loaded     <= 1'b0;
      cmd_ready      <= 1'b0;
      Krdy           <= 1'b0;
      Drdy           <= 1'b0;
      Key_ready_user <= 1'b0;
      reseed         <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_status     <= '0;
      rsp_data       <= '0;
      EN             <= 1'b0;
    end else begin
      state          <= state_d;
      op_q           <= op_d;
      cnt            <= cnt_d;
      key_loaded     <= key_loaded_d;
      cmd_ready      <= cmd_ready_d;
      Krdy           <= krdy_d;
      Drdy           <= drdy_d;
      Key_ready_user <= kru_d;
      reseed         <= reseed_d;
      rsp_valid      <= rsp_valid_d;
      rsp_status     <= rsp_status_d;
      rsp_data       <= rsp_data_d;
      EN             <= 1'b1;
    end
  end

  // Operand registers: written only by the accepted command that owns them
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      Kin       <= '0;
      Din       <= '0;
      Key       <= '0;
      Ukey_seed <= '0;
      User_IV   <= '0;
      newseed   <= '0;
      newIV     <= '0;
    end else if (accept_c) begin
      case (op_t'(cmd_op))
        OP_LOAD_KEY: Kin <= cmd_data;
        OP_ENCRYPT:  Din <= cmd_data;
        OP_UNLOCK: begin
          Key       <= cmd_key;
          Ukey_seed <= cmd_seed;
          User_IV   <= cmd_iv;
        end
        OP_RESEED: begin
          newseed <= cmd_seed;
          newIV   <= cmd_iv;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ho_host_seq.sv
// Bench for ho_host_seq: directed scenarios plus randomized commands scored against a
// latency/status model; a second instance with a short timeout covers the timeout paths.
module tb_ho_host_seq;

  logic         CLK, RSTn;
  logic         cmd_valid, cmd_valid_t;
  logic [1:0]   cmd_op;
  logic [127:0] cmd_data, Dout;
  logic [79:0]  cmd_seed, cmd_iv;
  logic [63:0]  cmd_key;
  logic         Kvld, Kvld_t, Dvld, BSY, done;

  logic         cmd_ready, rsp_valid, Krdy, Drdy, EN, reseed, Key_ready_user;
  logic [1:0]   rsp_status;
  logic [127:0] rsp_data, Kin, Din;
  logic [79:0]  newseed, newIV, Ukey_seed, User_IV;
  logic [63:0]  Key;

  logic         cmd_ready_t, rsp_valid_t, Krdy_t, Drdy_t, EN_t, reseed_t, Key_ready_user_t;
  logic [1:0]   rsp_status_t;
  logic [127:0] rsp_data_t, Kin_t, Din_t;
  logic [79:0]  newseed_t, newIV_t, Ukey_seed_t, User_IV_t;
  logic [63:0]  Key_t;

  int total = 0;
  int bad   = 0;
  bit sel   = 0;
  bit kl_m [2];

  ho_host_seq dut (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_seed(cmd_seed), .cmd_iv(cmd_iv), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .Kin(Kin), .Krdy(Krdy), .Kvld(Kvld), .Din(Din), .Drdy(Drdy), .Dvld(Dvld), .Dout(Dout),
    .BSY(BSY), .EN(EN), .reseed(reseed), .newseed(newseed), .newIV(newIV), .Key(Key),
    .Ukey_seed(Ukey_seed), .User_IV(User_IV), .Key_ready_user(Key_ready_user), .done(done)
  );

  ho_host_seq #(.TIMEOUT(15), .TO_W(4)) dut_to (
    .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_seed(cmd_seed), .cmd_iv(cmd_iv), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid_t), .rsp_status(rsp_status_t), .rsp_data(rsp_data_t),
    .Kin(Kin_t), .Krdy(Krdy_t), .Kvld(Kvld_t), .Din(Din_t), .Drdy(Drdy_t), .Dvld(Dvld),
    .Dout(Dout), .BSY(BSY), .EN(EN_t), .reseed(reseed_t), .newseed(newseed_t), .newIV(newIV_t),
    .Key(Key_t), .Ukey_seed(Ukey_seed_t), .User_IV(User_IV_t),
    .Key_ready_user(Key_ready_user_t), .done(done)
  );

  // Views onto whichever instance the current command targets
  wire         v_ready  = sel ? cmd_ready_t  : cmd_ready;
  wire         v_rsp    = sel ? rsp_valid_t  : rsp_valid;
  wire [1:0]   v_status = sel ? rsp_status_t : rsp_status;
  wire [127:0] v_data   = sel ? rsp_data_t   : rsp_data;
  wire [3:0]   v_str    = sel ? {Krdy_t, Drdy_t, Key_ready_user_t, reseed_t}
                              : {Krdy, Drdy, Key_ready_user, reseed};
  wire [127:0] v_kin    = sel ? Kin_t : Kin;
  wire [127:0] v_din    = sel ? Din_t : Din;
  wire [63:0]  v_key    = sel ? Key_t : Key;
  wire [79:0]  v_useed  = sel ? Ukey_seed_t : Ukey_seed;
  wire [79:0]  v_uiv    = sel ? User_IV_t : User_IV;
  wire [79:0]  v_nseed  = sel ? newseed_t : newseed;
  wire [79:0]  v_niv    = sel ? newIV_t : newIV;
  wire         v_kl     = sel ? dut_to.key_loaded : dut.key_loaded;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_ctl"}, {124'd0, cmd_ready, EN, rsp_valid, dut.key_loaded}, '0);
    chk({tag, "_str"}, {124'd0, Krdy, Drdy, Key_ready_user, reseed}, '0);
    chk({tag, "_rsp"}, {rsp_status, rsp_data[125:0]}, '0);
    chk({tag, "_rsp_hi"}, {126'd0, rsp_data[127:126]}, '0);
    chk({tag, "_kin"}, Kin, '0);
    chk({tag, "_din"}, Din, '0);
    chk({tag, "_key"}, {Key, newseed[63:0]}, '0);
    chk({tag, "_seeds"}, {newseed[79:64], newIV, Ukey_seed[79:48]}, '0);
    chk({tag, "_useed"}, {Ukey_seed[47:0], User_IV}, '0);
  endtask

  // One command, scored against expectations derived from the operation rules
  task automatic run_cmd(input bit s, input logic [1:0] op, input logic [127:0] data,
                         input logic [79:0] seed, input logic [79:0] iv, input logic [63:0] key,
                         input logic [127:0] dv, input int b, input int d, input bit stray,
                         input string tag);
    int tmo, w, k, sedge, redge, nstr, exp_edge, ack_edge, exp_nstr;
    logic [1:0]   exp_st;
    logic [127:0] exp_data;
    logic [3:0]   exp_which;
    bit           exp_kl, own;
    sel = s;
    tmo = s ? 15 : 1023;
    w = 0;
    while (!v_ready && w < 50) begin
      @(posedge CLK); @(negedge CLK); w++;
    end
    chk({tag, "_ready"}, 128'(v_ready), 128'd1);

    exp_which = 4'b1000 >> op;
    exp_data  = '0;
    exp_kl    = kl_m[s];
    exp_nstr  = 1;
    exp_st    = 2'd0;
    if (op == 2'd1 && !kl_m[s]) begin
      exp_edge = 1; exp_st = 2'd2; exp_nstr = 0;
    end else begin
      ack_edge = (op == 2'd3) ? b + 2 : ((d < 0) ? 1 << 30 : b + 2 + d);
      if (ack_edge <= tmo) begin
        exp_edge = ack_edge;
        if (op == 2'd1) exp_data = dv;
        if (op == 2'd0) exp_kl = 1'b1;
      end else begin
        exp_edge = tmo; exp_st = 2'd1;
        if (op == 2'd0) exp_kl = 1'b0;
      end
    end
    kl_m[s] = exp_kl;

    cmd_op = op; cmd_data = data; cmd_seed = seed; cmd_iv = iv; cmd_key = key; Dout = dv;
    if (s) cmd_valid_t = 1'b1; else cmd_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    cmd_valid = 1'b0; cmd_valid_t = 1'b0;

    k = 0; sedge = -1; redge = -1; nstr = 0;
    while (redge < 0 && k < 3000) begin
      own    = (sedge >= 0 && d >= 0 && k + 1 == sedge + 1 + d);
      Kvld   = stray && ($urandom_range(0, 3) == 0);
      Kvld_t = stray && ($urandom_range(0, 3) == 0);
      Dvld   = stray && ($urandom_range(0, 3) == 0);
      done   = stray && ($urandom_range(0, 3) == 0);
      case (op)
        2'd0: if (s) Kvld_t = own; else Kvld = own;
        2'd1: Dvld = own;
        2'd2: done = own;
        default: ;
      endcase
      BSY = (k + 1 <= b) ? 1'b1 : (sedge >= 0 && stray && $urandom_range(0, 1) == 0);
      @(posedge CLK); k++; @(negedge CLK);
      if (v_str != 4'd0) begin
        nstr += $countones(v_str);
        if (sedge < 0) begin
          sedge = k;
          chk({tag, "_which"}, 128'(v_str), 128'(exp_which));
          case (op)
            2'd0: chk({tag, "_kin"}, v_kin, data);
            2'd1: chk({tag, "_din"}, v_din, data);
            2'd2: chk({tag, "_unlock_ops"}, {v_key, v_useed[63:0]}, {key, seed[63:0]});
            default: chk({tag, "_reseed_ops"}, {32'd0, v_nseed[15:0], v_niv},
                         {32'd0, seed[15:0], iv});
          endcase
          if (op == 2'd2) chk({tag, "_unlock_iv"}, {32'd0, v_useed[79:64], v_uiv},
                              {32'd0, seed[79:64], iv});
          if (op == 2'd3) chk({tag, "_newseed"}, 128'(v_nseed), 128'(seed));
        end
      end
      if (v_rsp) redge = k;
    end

    chk({tag, "_nstrobe"}, 128'(nstr), 128'(exp_nstr));
    if (exp_nstr == 1) chk({tag, "_strobe_cyc"}, 128'(sedge), 128'(b + 1));
    chk({tag, "_rsp_cyc"}, 128'(redge), 128'(exp_edge));
    chk({tag, "_status"}, 128'(v_status), 128'(exp_st));
    chk({tag, "_data"}, v_data, exp_data);
    chk({tag, "_key_loaded"}, 128'(v_kl), 128'(exp_kl));

    Kvld = 1'b0; Kvld_t = 1'b0; Dvld = 1'b0; done = 1'b0; BSY = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk({tag, "_pulse"}, 128'(v_rsp), 128'd0);
    chk({tag, "_hold"}, {v_status, v_data[125:0]}, {exp_st, exp_data[125:0]});
  endtask

  initial begin
    logic [127:0] pt, rd, rdv;
    logic [79:0]  rs, ri;
    logic [63:0]  rk;
    int           n, op_i, b_i, d_i;

    RSTn = 1'b0; cmd_valid = 1'b0; cmd_valid_t = 1'b0; cmd_op = '0; cmd_data = '0;
    cmd_seed = '0; cmd_iv = '0; cmd_key = '0; Kvld = 1'b0; Kvld_t = 1'b0; Dvld = 1'b0;
    Dout = '0; BSY = 1'b0; done = 1'b0;
    kl_m[0] = 1'b0; kl_m[1] = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_main_zero("reset");
    chk("reset_to", {124'd0, cmd_ready_t, EN_t, rsp_valid_t, Krdy_t}, '0);
    RSTn = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("en_after_reset", {126'd0, EN, EN_t}, 128'd3);

    pt = 128'h000102030405060708090A0B0C0D0E0F;
    run_cmd(0, 2'd1, pt, '0, '0, '0, '0, 0, 0, 0, "nokey");
    run_cmd(0, 2'd0, pt, '0, '0, '0, '0, 0, 9, 0, "load_key");
    run_cmd(0, 2'd1, pt, '0, '0, '0, 128'h0A940BB5416EF045F1C39458C653EA5A, 3, 0, 0, "encrypt");
    run_cmd(0, 2'd2, '0, 80'h0053A6F94C9FF24598EB, 80'h0D74DB42A91077DE45AC,
            64'h5468617473206D79, '0, 0, 19, 0, "unlock");
    run_cmd(0, 2'd3, '0, 80'h9953A6F94C9FF24598EB, 80'h0D74DB42A91077DE45AC, '0, '0, 0, 0, 0,
            "reseed");

    rd = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_cmd(1, 2'd0, rd, '0, '0, '0, '0, 0, 2, 1, "to_load_ok");
    run_cmd(1, 2'd0, ~rd, '0, '0, '0, '0, 0, -1, 1, "to_timeout");
    sel = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      Kvld_t = i[0];
      @(posedge CLK); @(negedge CLK);
      if (rsp_valid_t) n++;
    end
    Kvld_t = 1'b0;
    chk("to_stray_rsp", 128'(n), 128'd0);
    chk("to_stray_kl", 128'(dut_to.key_loaded), 128'd0);
    run_cmd(1, 2'd0, rd, '0, '0, '0, '0, 0, 13, 1, "to_ack_wins");

    for (int i = 0; i < 40; i++) begin
      op_i = int'($urandom_range(0, 3));
      b_i  = (op_i == 1) ? int'($urandom_range(0, 4)) : 0;
      d_i  = int'($urandom_range(0, 12));
      rd   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rdv  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rs   = {16'($urandom()), $urandom(), $urandom()};
      ri   = {16'($urandom()), $urandom(), $urandom()};
      rk   = {$urandom(), $urandom()};
      run_cmd(0, 2'(op_i), rd, rs, ri, rk, rdv, b_i, d_i, 1, "rand");
    end

    // Abort an ENCRYPT while it waits for Dvld
    sel = 1'b0;
    if (!kl_m[0]) run_cmd(0, 2'd0, pt, '0, '0, '0, '0, 0, 1, 0, "pre_abort_load");
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge CLK); @(negedge CLK); n++;
    end
    cmd_op = 2'd1; cmd_data = pt; BSY = 1'b0; Dvld = 1'b0; Kvld = 1'b0; done = 1'b0;
    cmd_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    cmd_valid = 1'b0;
    n = 0;
    repeat (3) begin
      @(posedge CLK); @(negedge CLK);
      if (rsp_valid) n++;
    end
    RSTn = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk_main_zero("abort");
    @(posedge CLK); @(negedge CLK);
    if (rsp_valid) n++;
    RSTn = 1'b1;
    kl_m[0] = 1'b0; kl_m[1] = 1'b0;
    @(posedge CLK); @(negedge CLK);
    if (rsp_valid) n++;
    chk("abort_no_rsp", 128'(n), 128'd0);
    chk("abort_en", {126'd0, EN, cmd_ready}, 128'd3);
    run_cmd(0, 2'd1, pt, '0, '0, '0, '0, 0, 0, 0, "nokey_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ho_host_seq.md
# ho_host_seq

Host-side command sequencer that drives the obfuscated AES core's handshake interface as initiator. It accepts one command at a time from an upstream controller (load key, encrypt block, user-key unlock, PRNG reseed) and emits the matching strobe with registered operands. It then waits for the core's acknowledge, or for a timeout, and returns one response per command. It sits between a bus/UART command front end and `HO_main`, replacing hand-driven testbench stimulus in the system build.

## Interface
- `TIMEOUT`, 1023: maximum cycles spent in ISSUE+WAIT before abandoning a command.
- `TO_W`, 10: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

- `CLK` in 1: single clock; all logic is on the rising edge.
- `RSTn` in 1: reset, synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer idle; the command is accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 0 LOAD_KEY, 1 ENCRYPT, 2 UNLOCK, 3 RESEED.
- `cmd_data` in 128: key for LOAD_KEY, plaintext for ENCRYPT.
- `cmd_seed` in 80: seed for RESEED and UNLOCK.
- `cmd_iv` in 80: IV for RESEED and UNLOCK.
- `cmd_key` in 64: user key for UNLOCK.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_status` out 2: 0 OK, 1 TIMEOUT, 2 NOKEY.
- `rsp_data` out 128: captured `Dout` for ENCRYPT; 0 for every other op.
- `Kin` out 128, `Krdy` out 1, `Kvld` in 1: key-load channel.
- `Din` out 128, `Drdy` out 1, `Dvld` in 1, `Dout` in 128, `BSY` in 1: data channel.
- `EN` out 1: core enable.
- `reseed` out 1, `newseed` out 80, `newIV` out 80: PRNG reseed channel.
- `Key` out 64, `Ukey_seed` out 80, `User_IV` out 80, `Key_ready_user` out 1, `done` in 1: user-key unlock channel.

## Operation
- **States:** IDLE, ISSUE, WAIT.
  - `cmd_ready` = (state == IDLE) and not in reset.
- **Accept (IDLE):**
  - Operands are latched into the corresponding output registers: `Kin`/`Din` from `cmd_data`; `newseed`/`Ukey_seed` from `cmd_seed`; `newIV`/`User_IV` from `cmd_iv`; `Key` from `cmd_key`.
  - The timeout counter is cleared and the FSM goes to ISSUE.
  - Operand outputs hold until the next accepted command that writes them.
- **ENCRYPT with `key_loaded` = 0:** no strobe is issued. `rsp_status` = 2 is returned and the FSM goes directly back to IDLE.
- **ISSUE:**
  - For ENCRYPT, the FSM waits until `BSY` = 0.
  - All other ops proceed immediately.
  - On exit, exactly one strobe (`Krdy`, `Drdy`, `Key_ready_user` or `reseed`) is registered high for one cycle and the FSM goes to WAIT.
- **WAIT:** the acknowledge is `Kvld` (LOAD_KEY), `Dvld` (ENCRYPT) or `done` (UNLOCK).
  - RESEED has no acknowledge and completes OK on the first WAIT edge.
  - On acknowledge:
    - Capture `Dout` into `rsp_data` for ENCRYPT.
    - Set `key_loaded` for LOAD_KEY.
    - Return status OK and go to IDLE.
- **Timeout:**
  - The counter increments on every ISSUE/WAIT cycle.
  - When it reaches `TIMEOUT` with no acknowledge, the sequencer returns status 1 and goes to IDLE.
  - A LOAD_KEY timeout clears `key_loaded`.
- **Stray acknowledges:** late or unsolicited `Kvld`/`Dvld`/`done` seen in IDLE, or while waiting on a different op, are ignored.
- **Acknowledge and timeout on the same edge:** the acknowledge wins (status OK).
- **`EN`:** 0 in reset, 1 one cycle after reset is released.

## Timing
- **Reset value of every output:** 0, applied on the first edge with `RSTn` = 0. This includes `cmd_ready`, all strobes, `rsp_*`, all operand registers and `key_loaded`.
- **Reset mid-command:** the FSM aborts to IDLE, any strobe drops at that edge, and no response is emitted.
- **Accept-to-strobe cycle:** accept at edge E0 → strobe high in [E1, E2), assuming `BSY` = 0.
- **Acknowledge sampling:** the earliest acknowledge is sampled at E2 → `rsp_valid` high in [E2, E3), and `cmd_ready` is high from E2.
  - Minimum command-to-response latency is 2 cycles.
- **Back-to-back commands:** a new command may be accepted on the same edge `rsp_valid` falls.
- **Strobe width:** exactly 1 cycle, never re-issued within one command.
- **`rsp_valid`:** a 1-cycle pulse with no back-pressure. `rsp_data` and `rsp_status` hold until the next response.
- **NOKEY latency:** accept at E0 → `rsp_valid` in [E1, E2).

## Test plan
- **Key load:** LOAD_KEY with `cmd_data` = 128'h000102030405060708090A0B0C0D0E0F; the model asserts `Kvld` 10 cycles after `Krdy`.
  - Required: a single `Krdy` pulse with `Kin` equal to that value, then `rsp_status` = 0, `rsp_data` = 0 and `key_loaded` = 1.
- **Encrypt:** ENCRYPT with the same plaintext; the model holds `BSY` for 3 cycles, then pulses `Dvld` with `Dout` = 128'h0A940BB5416EF045F1C39458C653EA5A.
  - Required: `Drdy` is not issued until `BSY` = 0, and `rsp_data` equals that `Dout` with status 0.
- **No key after reset:** ENCRYPT immediately after reset.
  - Required: no `Drdy`, `rsp_status` = 2 one cycle after accept.
- **Unlock, then reseed:** UNLOCK with `Key` = 64'h5468617473206D79, seed 80'h0053A6F94C9FF24598EB, IV 80'h0D74DB42A91077DE45AC; the model raises `done` after 20 cycles.
  - Then RESEED with seed 80'h9953A6F94C9FF24598EB.
  - Required: status 0 for both, the RESEED response arrives 2 cycles after accept, and the `newseed` output is correct.
- **Timeout:** `TIMEOUT` = 15 and a model that never sends `Kvld`.
  - Required: status 1 exactly 15 cycles after accept, `key_loaded` = 0, and a later stray `Kvld` is ignored with no extra `rsp_valid`.
- **Reset mid-op:** `RSTn` pulsed low during WAIT of an ENCRYPT.
  - Required: all outputs are 0 at the next edge, no response is emitted, and ENCRYPT after reset returns status 2.
